// File: rtl/ccff_cfg_pkg.sv
// Shared types and CRC helper for the CCFF configuration chain loader.
package ccff_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CHECK  = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_FAIL   = 3'd5
  } ccff_ld_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;

  // One bit of CRC-16-CCITT, MSB feedback.
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that hands host words to the chain LSB-first, dropping the
// bits of the final word that lie beyond the end of the chain.
module ccff_word_serializer
  import ccff_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_bit,
  output logic              o_bit_vld
);

  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
  localparam int IDX_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WCNT_W    = $clog2(N_WORDS + 1);

  logic [WORD_W-1:0] r_buf;
  logic              r_full;
  logic [IDX_W-1:0]  r_idx;
  logic              r_last_word;
  logic [WCNT_W-1:0] r_wcnt;

  logic [IDX_W-1:0]  w_last_idx;
  logic              w_last_bit;
  logic              w_more;
  logic              w_accept;

  assign w_last_idx = r_last_word ? IDX_W'(LAST_BITS - 1) : IDX_W'(WORD_W - 1);
  assign w_last_bit = r_full && (r_idx == w_last_idx);
  assign w_more     = (r_wcnt < WCNT_W'(N_WORDS));
  // Refill while the last bit is leaving so words stream without a bubble.
  assign o_ready    = i_en && w_more && (!r_full || w_last_bit);
  assign w_accept   = o_ready && i_valid;
  assign o_bit_vld  = i_en && r_full;
  assign o_bit      = r_full ? r_buf[r_idx] : 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_buf       <= {WORD_W{1'b0}};
      r_full      <= 1'b0;
      r_idx       <= {IDX_W{1'b0}};
      r_last_word <= 1'b0;
      r_wcnt      <= {WCNT_W{1'b0}};
    end else if (w_accept) begin
      r_buf       <= i_data;
      r_full      <= 1'b1;
      r_idx       <= {IDX_W{1'b0}};
      r_last_word <= (r_wcnt == WCNT_W'(N_WORDS - 1));
      r_wcnt      <= r_wcnt + WCNT_W'(1);
    end else if (w_last_bit) begin
      r_full <= 1'b0;
      r_idx  <= {IDX_W{1'b0}};
    end else if (r_full) begin
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a CCFF configuration chain from a host word stream, optionally
// recirculates it once to CRC-check its contents, then applies the config.
module ccff_chain_loader
  import ccff_cfg_pkg::*;
#(
  parameter int  CHAIN_LEN = 64,
  parameter int  WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic              VERIFY_EN,
  input  logic [WORD_W-1:0] CFG_DATA,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  output logic              CHAIN_D,
  output logic              CHAIN_SHIFT_EN,
  input  logic              CHAIN_Q,
  output logic              CFG_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  ccff_ld_state_t r_state;
  ccff_ld_state_t w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_crc_ref;
  logic [15:0]      r_crc_chk;
  logic             r_verify;
  logic             r_cfg_en;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic w_start_ok;
  logic w_last_cnt;
  logic w_ser_bit;
  logic w_ser_vld;
  logic w_ser_ready;

  assign w_start_ok = START && ((r_state == ST_IDLE) || (r_state == ST_ACTIVE) ||
                                (r_state == ST_FAIL));
  assign w_last_cnt = (r_cnt == CNT_W'(CHAIN_LEN - 1));

  ccff_word_serializer #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_ser (
    .i_clk    (CK),
    .i_rst    (RST),
    .i_clr    (w_start_ok),
    .i_en     (r_state == ST_LOAD),
    .i_data   (CFG_DATA),
    .i_valid  (CFG_VALID),
    .o_ready  (w_ser_ready),
    .o_bit    (w_ser_bit),
    .o_bit_vld(w_ser_vld)
  );

  assign CFG_READY = w_ser_ready;
  assign CFG_EN    = r_cfg_en;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ACTIVE, ST_FAIL: begin
        if (START) w_next = ST_LOAD;
        else       w_next = r_state;
      end
      ST_LOAD: begin
        if (w_ser_vld && w_last_cnt) w_next = r_verify ? ST_VERIFY : ST_ACTIVE;
        else                         w_next = r_state;
      end
      ST_VERIFY: begin
        if (w_last_cnt) w_next = ST_CHECK;
        else            w_next = r_state;
      end
      ST_CHECK: begin
        if (r_crc_ref == r_crc_chk) w_next = ST_ACTIVE;
        else                        w_next = ST_FAIL;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Chain head mux; during verify the tail feeds straight back to the head.
  always_comb begin
    CHAIN_D        = 1'b0;
    CHAIN_SHIFT_EN = 1'b0;
    case (r_state)
      ST_LOAD: begin
        CHAIN_D        = w_ser_bit;
        CHAIN_SHIFT_EN = w_ser_vld;
      end
      ST_VERIFY: begin
        CHAIN_D        = CHAIN_Q;
        CHAIN_SHIFT_EN = 1'b1;
      end
      default: begin
        CHAIN_D        = 1'b0;
        CHAIN_SHIFT_EN = 1'b0;
      end
    endcase
  end

  // State, status flags, bit counter and both CRCs.
  always_ff @(posedge CK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_crc_ref <= 16'h0000;
      r_crc_chk <= 16'h0000;
      r_verify  <= 1'b0;
      r_cfg_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cfg_en <= (w_next == ST_ACTIVE);
      r_busy   <= (w_next == ST_LOAD) || (w_next == ST_VERIFY) || (w_next == ST_CHECK);
      r_done   <= (w_next == ST_ACTIVE) && (r_state != ST_ACTIVE);
      r_err    <= (w_next == ST_FAIL);
      case (r_state)
        ST_IDLE, ST_ACTIVE, ST_FAIL: begin
          if (START) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_crc_ref <= CRC16_SEED;
            r_crc_chk <= CRC16_SEED;
            r_verify  <= VERIFY_EN;
          end
        end
        ST_LOAD: begin
          if (w_ser_vld) begin
            r_crc_ref <= crc16_bit(r_crc_ref, w_ser_bit);
            r_cnt     <= w_last_cnt ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
            if (w_last_cnt) r_crc_chk <= CRC16_SEED;
          end
        end
        ST_VERIFY: begin
          r_crc_chk <= crc16_bit(r_crc_chk, CHAIN_Q);
          r_cnt     <= w_last_cnt ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

endmodule
